instr_prefetch_unit: RTL and testbench

//  Instruction prefetch queue between the synchronous instruction ROM and the CPU's IR load.

---
 rtl/instr_prefetch_if.sv | 29 ++
 rtl/instr_prefetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// Bundle of the CPU fetch handshake, the ROM read port and the status
// outputs of the instruction prefetch unit.
interface instr_prefetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 3
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              ir_valid;
  logic [31:0]       ir;
  logic              busy;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [CNT_W-1:0]  q_count;
  logic [15:0]       redirects;

  // CPU and ROM side
  modport master (
    output fetch_req, fetch_addr, mem_rdata,
    input  ir_valid, ir, busy, mem_en, mem_addr, q_count, redirects
  );

  // prefetch unit side
  modport slave (
    input  fetch_req, fetch_addr, mem_rdata,
    output ir_valid, ir, busy, mem_en, mem_addr, q_count, redirects
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetch FIFO between the ROM and the CPU IR load;
// serves fetches from the FIFO head and flushes/redirects on a mismatch.
module instr_prefetch_unit #(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        STEP     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input logic             CP,
  input logic             reset,
  instr_prefetch_if.slave bus
);
  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_V = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_M = {{(ADDR_W - 2){1'b1}}, 2'b00};

  typedef enum logic [0:0] {ST_STREAM = 1'b0, ST_REDIRECT = 1'b1} state_t;

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
  logic [31:0]       fifo_data_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] pf_ptr_r, tag_r, req_addr_r;
  logic              inflight_r, busy_r, ir_valid_r;
  logic [31:0]       ir_r;
  logic [15:0]       redirects_r;

  logic [ADDR_W-1:0] req_eff_s;
  logic [CNT_W:0]    occ_s;
  logic              active_s, empty_s, issue_s;
  logic              hit_s, bypass_s, miss_s, deliver_s, push_s, pop_s;

  // serve decision, issue condition and next FSM state
  always_comb begin
    req_eff_s  = busy_r ? req_addr_r : (bus.fetch_addr & ALIGN_M);
    active_s   = busy_r | bus.fetch_req;
    empty_s    = (count_r == {CNT_W{1'b0}});
    occ_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s    = (occ_s < DEPTH_V) | (state_r == ST_REDIRECT);
    hit_s      = 1'b0;
    bypass_s   = 1'b0;
    miss_s     = 1'b0;
    if (active_s) begin
      if (!empty_s) begin
        if (fifo_addr_r[rd_ptr_r] == req_eff_s) begin
          hit_s = 1'b1;
        end else begin
          miss_s = 1'b1;
        end
      end else if (inflight_r && (tag_r == req_eff_s)) begin
        bypass_s = 1'b1;
      end else if (pf_ptr_r == req_eff_s) begin
        miss_s = 1'b0;          // wait for the word already on its way
      end else begin
        miss_s = 1'b1;
      end
    end else begin
      miss_s = 1'b0;
    end
    deliver_s = hit_s | bypass_s;
    pop_s     = hit_s;
    push_s    = inflight_r & ~bypass_s & ~miss_s;
    case (state_r)
      ST_STREAM:   state_nx_s = miss_s ? ST_REDIRECT : ST_STREAM;
      ST_REDIRECT: state_nx_s = miss_s ? ST_REDIRECT : ST_STREAM;
      default:     state_nx_s = ST_STREAM;
    endcase
  end

  // FSM state register
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      state_r <= ST_STREAM;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FIFO, prefetch pointer, in-flight tracking and CPU-facing registers
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= 32'h0000_0000;
      end
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      pf_ptr_r    <= RESET_PC;
      tag_r       <= {ADDR_W{1'b0}};
      inflight_r  <= 1'b0;
      req_addr_r  <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      ir_valid_r  <= 1'b0;
      ir_r        <= 32'h0000_0000;
      redirects_r <= 16'h0000;
    end else begin
      ir_valid_r <= deliver_s;
      busy_r     <= active_s & ~deliver_s;
      if (active_s) begin
        req_addr_r <= req_eff_s;
      end
      if (hit_s) begin
        ir_r <= fifo_data_r[rd_ptr_r];
      end else if (bypass_s) begin
        ir_r <= bus.mem_rdata;
      end
      if (miss_s) begin
        // the return landing now and any issue this edge both belong to the old stream
        rd_ptr_r   <= {PTR_W{1'b0}};
        wr_ptr_r   <= {PTR_W{1'b0}};
        count_r    <= {CNT_W{1'b0}};
        inflight_r <= 1'b0;
        pf_ptr_r   <= req_eff_s;
        if (redirects_r != 16'hFFFF) begin
          redirects_r <= redirects_r + 16'd1;
        end
      end else begin
        if (push_s) begin
          fifo_addr_r[wr_ptr_r] <= tag_r;
          fifo_data_r[wr_ptr_r] <= bus.mem_rdata;
          wr_ptr_r              <= wr_ptr_r + 1'b1;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
        count_r    <= count_r + {{(CNT_W - 1){1'b0}}, push_s}
                              - {{(CNT_W - 1){1'b0}}, pop_s};
        inflight_r <= issue_s;
        if (issue_s) begin
          tag_r    <= pf_ptr_r;
          pf_ptr_r <= pf_ptr_r + STEP_V;
        end
      end
    end
  end

  assign bus.mem_en    = reset & issue_s;
  assign bus.mem_addr  = reset ? pf_ptr_r : {ADDR_W{1'b0}};
  assign bus.ir_valid  = ir_valid_r;
  assign bus.ir        = ir_r;
  assign bus.busy      = busy_r;
  assign bus.q_count   = count_r;
  assign bus.redirects = redirects_r;
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomized scoreboard bench for instr_prefetch_unit with a queue-based
// reference model of the prefetch stream and a behavioural ROM.
module tb_instr_prefetch_unit;
  localparam int DEPTH = 4;

  logic CP    = 1'b0;
  logic reset = 1'b0;

  instr_prefetch_if #(.ADDR_W(8), .CNT_W(3)) bus ();

  instr_prefetch_unit #(.DEPTH(4), .ADDR_W(8), .STEP(4), .RESET_PC(8'h00)) dut (
    .CP    (CP),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CP = ~CP;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {a ^ 8'hA5, ~a, a + 8'h3C, a};
  endfunction

  // synchronous ROM: data valid the cycle after mem_en is sampled
  always @(posedge CP) begin
    if (bus.mem_en) bus.mem_rdata <= rom(bus.mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0]  mq[$];       // addresses held in the prefetch queue
  logic [31:0] sb[$];       // expected ir words for accepted requests
  bit          m_infl, m_busy, m_redir, m_irv;
  logic [7:0]  m_tag, m_pf, m_req;
  logic [15:0] m_redirects;
  logic [31:0] m_ir;

  task automatic model_reset();
    mq.delete(); sb.delete();
    m_infl = 0; m_busy = 0; m_redir = 0; m_irv = 0;
    m_tag = 8'h00; m_pf = 8'h00; m_req = 8'h00;
    m_redirects = 16'h0000; m_ir = 32'h0;
  endtask

  task automatic model_step();
    bit en, active, deliver, miss, ret;
    logic [7:0] req;
    en     = ((mq.size() + int'(m_infl)) < DEPTH) || m_redir;
    active = m_busy || bus.fetch_req;
    req    = m_busy ? m_req : {bus.fetch_addr[7:2], 2'b00};
    if (bus.fetch_req && !m_busy) sb.push_back(rom(req));
    ret = m_infl; deliver = 0; miss = 0;
    if (active) begin
      if (mq.size() != 0) begin
        if (mq[0] == req) begin deliver = 1; void'(mq.pop_front()); end
        else miss = 1;
      end else if (m_infl && m_tag == req) begin
        deliver = 1; ret = 0;
      end else if (m_pf != req) begin
        miss = 1;
      end
    end
    if (deliver) m_ir = rom(req);
    m_irv = deliver;
    m_busy = active && !deliver;
    m_req = req;
    m_redir = miss;
    if (miss) begin
      mq.delete(); m_infl = 0; m_pf = req;
      if (m_redirects != 16'hFFFF) m_redirects = m_redirects + 16'd1;
    end else begin
      if (ret) mq.push_back(m_tag);
      m_infl = en;
      if (en) begin m_tag = m_pf; m_pf = m_pf + 8'd4; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CP or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // monitor: compare outputs against the model, pop the scoreboard on ir_valid
  always @(negedge CP) begin
    logic [31:0] exp_ir;
    check("ir_valid", 32'(bus.ir_valid), 32'(m_irv));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("q_count", 32'(bus.q_count), 32'(mq.size()));
    check("mem_en", 32'(bus.mem_en),
          32'(reset && (((mq.size() + int'(m_infl)) < DEPTH) || m_redir)));
    check("mem_addr", 32'(bus.mem_addr), 32'(reset ? m_pf : 8'h00));
    check("redirects", 32'(bus.redirects), 32'(m_redirects));
    if (bus.ir_valid) begin
      check("ir_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_ir = sb.pop_front();
        check("ir", bus.ir, exp_ir);
      end
    end else begin
      check("ir_hold", bus.ir, m_ir);
    end
  end

  task automatic do_reset();
    @(negedge CP); #2 reset = 1'b0; bus.fetch_req = 1'b0;
    @(negedge CP); #2 reset = 1'b1;
  endtask

  task automatic wait_irv(inout int lat);
    while (!bus.ir_valid && lat < 20) begin @(negedge CP); lat++; end
  endtask

  task automatic fetch(input logic [7:0] a, output int lat);
    int guard;
    guard = 0;
    while (m_busy && guard < 50) begin @(negedge CP); guard++; end
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    @(negedge CP);
    bus.fetch_req = 1'b0;
    lat = 1;
    wait_irv(lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, dut_n, guard, r;
    logic [7:0] a, base;
    bus.fetch_req = 1'b0; bus.fetch_addr = 8'h00;
    do_reset();

    // fill after reset
    repeat (6) @(negedge CP);
    check("p1_q_full", 32'(bus.q_count), 32'd4);
    check("p1_mem_en_full", 32'(bus.mem_en), 32'd0);

    // sequential hits, one per two cycles
    for (int i = 0; i < 3; i++) begin
      fetch(8'(4 * i), lat);
      check("p2_hit_lat", 32'(lat), 32'd1);
      @(negedge CP);
    end
    check("p2_redirects", 32'(bus.redirects), 32'd0);

    // miss with a full FIFO of 00..0C
    do_reset();
    repeat (6) @(negedge CP);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h40;
    @(negedge CP);
    bus.fetch_req = 1'b0;
    check("p3_q_flush", 32'(bus.q_count), 32'd0);
    check("p3_mem_addr", 32'(bus.mem_addr), 32'h40);
    check("p3_mem_en", 32'(bus.mem_en), 32'd1);
    lat = 1;
    wait_irv(lat);
    check("p3_miss_lat", 32'(lat), 32'd3);
    check("p3_redirects", 32'(bus.redirects), 32'd1);

    // wrap of the prefetch pointer past 0xFC
    @(negedge CP);
    fetch(8'hF8, lat);
    check("p4_miss_lat", 32'(lat), 32'd3);
    repeat (6) @(negedge CP);
    fetch(8'hFC, lat);
    check("p4_hit_fc", 32'(lat), 32'd1);
    @(negedge CP);
    fetch(8'h00, lat);
    check("p4_hit_00", 32'(lat), 32'd1);
    check("p4_redirects", 32'(bus.redirects), 32'd2);

    // reset while a miss is in flight
    @(negedge CP);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h80;
    @(negedge CP);
    bus.fetch_req = 1'b0;
    @(negedge CP);
    #2 reset = 1'b0;
    #1;
    check("p5_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("p5_ir", bus.ir, 32'd0);
    check("p5_busy", 32'(bus.busy), 32'd0);
    check("p5_mem_en", 32'(bus.mem_en), 32'd0);
    check("p5_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("p5_q_count", 32'(bus.q_count), 32'd0);
    check("p5_redirects", 32'(bus.redirects), 32'd0);
    @(negedge CP);
    #2 reset = 1'b1;
    #1;
    check("p5_restart_addr", 32'(bus.mem_addr), 32'h00);
    check("p5_restart_en", 32'(bus.mem_en), 32'd1);

    // fetch_req held high, address stepping on each delivery
    repeat (6) @(negedge CP);
    a = 8'h00; n = 0; dut_n = 0; guard = 0;
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    while (n < 8 && guard < 60) begin
      @(negedge CP);
      guard++;
      if (bus.ir_valid) dut_n++;
      if (m_irv) begin
        n++;
        a = a + 8'd4;
        bus.fetch_addr = (n == 3) ? (a | 8'h03) : a;
      end
    end
    bus.fetch_req = 1'b0;
    check("p6_deliveries", 32'(n), 32'd8);
    check("p6_dut_pulses", 32'(dut_n), 32'd8);

    // randomized traffic
    repeat (600) begin
      @(negedge CP);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b0;
        @(negedge CP);
        #2 reset = 1'b1;
      end else begin
        bus.fetch_req = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 6)      base = m_req + 8'd4;
        else if (r < 8) base = m_req + 8'(4 * $urandom_range(2, 5));
        else            base = 8'($urandom);
        bus.fetch_addr = {base[7:2], 2'($urandom)};
      end
    end
    @(negedge CP);
    bus.fetch_req = 1'b0;
    guard = 0;
    while (m_busy && guard < 30) begin @(negedge CP); guard++; end
    repeat (2) @(negedge CP);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
